// File: rtl/oled_spi_scheduler_pkg.sv
// ---------------------------------------------------------------------------
// oled_spi_scheduler_pkg: shared state/owner encodings for the OLED SPI scheduler
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package oled_spi_scheduler_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_LAUNCH    = 2'd1,
    ST_WAIT_DONE = 2'd2,
    ST_GAP       = 2'd3
  } state_e;

  localparam logic [1:0] OWNER_NONE = 2'b00;
  localparam logic [1:0] OWNER_INIT = 2'b01;
  localparam logic [1:0] OWNER_USER = 2'b10;

  // Bits needed to hold 0..n-1, never less than one bit.
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

`default_nettype wire

// File: rtl/oled_spi_scheduler_prio_arb.sv
// ---------------------------------------------------------------------------
// oled_spi_prio_arb: two-input fixed-priority arbiter (init over user) with burst lock
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module oled_spi_prio_arb
  import oled_spi_scheduler_pkg::*;
(
  input  logic       req_init_i,
  input  logic       req_user_i,
  input  logic       lock_i,
  input  logic [1:0] lock_owner_i,
  output logic [1:0] grant_o
);

  // While locked only the current owner may be granted again; no preemption.
  always_comb begin
    grant_o = OWNER_NONE;
    if (lock_i) begin
      if ((lock_owner_i == OWNER_INIT) && req_init_i) begin
        grant_o = OWNER_INIT;
      end else if ((lock_owner_i == OWNER_USER) && req_user_i) begin
        grant_o = OWNER_USER;
      end
    end else if (req_init_i) begin
      grant_o = OWNER_INIT;
    end else if (req_user_i) begin
      grant_o = OWNER_USER;
    end
  end

endmodule

`default_nettype wire

// File: rtl/oled_spi_scheduler.sv
// ---------------------------------------------------------------------------
// oled_spi_scheduler: shares one SPI byte transmitter between init and user requesters
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module oled_spi_scheduler
  import oled_spi_scheduler_pkg::*;
#(
  parameter int DATA_WIDTH     = 8,
  parameter int GAP_CYCLES     = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  init_req_i,
  input  logic                  init_dc_i,
  input  logic [DATA_WIDTH-1:0] init_data_i,
  output logic                  init_ack_o,
  input  logic                  user_req_i,
  input  logic                  user_dc_i,
  input  logic [DATA_WIDTH-1:0] user_data_i,
  output logic                  user_ack_o,
  output logic                  spi_start_o,
  output logic [DATA_WIDTH-1:0] spi_data_o,
  input  logic                  spi_done_i,
  output logic                  dc_o,
  output logic [1:0]            owner_o,
  output logic                  busy_o,
  output logic                  err_o
);

  localparam int TO_W  = cnt_width(TIMEOUT_CYCLES);
  localparam int GAP_W = cnt_width(GAP_CYCLES);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);

  state_e                state_q,    state_d;
  logic [1:0]            owner_q,    owner_d;
  logic [DATA_WIDTH-1:0] data_q,     data_d;
  logic                  dc_q,       dc_d;
  logic                  start_q,    start_d;
  logic                  init_ack_q, init_ack_d;
  logic                  user_ack_q, user_ack_d;
  logic                  busy_q,     busy_d;
  logic                  err_q,      err_d;
  logic [TO_W-1:0]       to_cnt_q,   to_cnt_d;
  logic [GAP_W-1:0]      gap_cnt_q,  gap_cnt_d;
  logic [1:0]            arm_q,      arm_d;
  logic [1:0]            grant;
  logic                  launch;

  oled_spi_prio_arb u_arb (
    .req_init_i   (init_req_i),
    .req_user_i   (user_req_i),
    .lock_i       (state_q == ST_GAP),
    .lock_owner_i (owner_q),
    .grant_o      (grant)
  );

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    data_d     = data_q;
    dc_d       = dc_q;
    start_d    = 1'b0;
    init_ack_d = 1'b0;
    user_ack_d = 1'b0;
    err_d      = err_q;
    to_cnt_d   = to_cnt_q;
    gap_cnt_d  = gap_cnt_q;
    launch     = 1'b0;
    // Two-flop arming keeps the first start at least two cycles after reset release.
    arm_d      = {arm_q[0], 1'b1};

    case (state_q)
      ST_IDLE: begin
        if (arm_q[1] && (grant != OWNER_NONE)) begin
          state_d = ST_LAUNCH;
          owner_d = grant;
          launch  = 1'b1;
        end
      end
      ST_LAUNCH: begin
        to_cnt_d = '0;
        state_d  = ST_WAIT_DONE;
      end
      ST_WAIT_DONE: begin
        if (spi_done_i) begin
          state_d   = ST_GAP;
          gap_cnt_d = GAP_LAST;
        end else if (to_cnt_q == TO_LAST) begin
          state_d = ST_IDLE;
          owner_d = OWNER_NONE;
          err_d   = 1'b1;
        end else begin
          to_cnt_d = to_cnt_q + TO_W'(1);
        end
      end
      ST_GAP: begin
        if (gap_cnt_q == '0) begin
          if (grant != OWNER_NONE) begin
            state_d = ST_LAUNCH;
            launch  = 1'b1;
          end else begin
            state_d = ST_IDLE;
            owner_d = OWNER_NONE;
          end
        end else begin
          gap_cnt_d = gap_cnt_q - GAP_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        owner_d = OWNER_NONE;
      end
    endcase

    // Outputs are registered on entry to LAUNCH so start, ack and data align in that cycle.
    if (launch) begin
      start_d    = 1'b1;
      init_ack_d = (grant == OWNER_INIT);
      user_ack_d = (grant == OWNER_USER);
      data_d     = (grant == OWNER_INIT) ? init_data_i : user_data_i;
      dc_d       = (grant == OWNER_INIT) ? init_dc_i   : user_dc_i;
    end

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      owner_q    <= OWNER_NONE;
      data_q     <= '0;
      dc_q       <= 1'b0;
      start_q    <= 1'b0;
      init_ack_q <= 1'b0;
      user_ack_q <= 1'b0;
      busy_q     <= 1'b0;
      err_q      <= 1'b0;
      to_cnt_q   <= '0;
      gap_cnt_q  <= '0;
      arm_q      <= 2'b00;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      data_q     <= data_d;
      dc_q       <= dc_d;
      start_q    <= start_d;
      init_ack_q <= init_ack_d;
      user_ack_q <= user_ack_d;
      busy_q     <= busy_d;
      err_q      <= err_d;
      to_cnt_q   <= to_cnt_d;
      gap_cnt_q  <= gap_cnt_d;
      arm_q      <= arm_d;
    end
  end

  assign init_ack_o  = init_ack_q;
  assign user_ack_o  = user_ack_q;
  assign spi_start_o = start_q;
  assign spi_data_o  = data_q;
  assign dc_o        = dc_q;
  assign owner_o     = owner_q;
  assign busy_o      = busy_q;
  assign err_o       = err_q;

endmodule

`default_nettype wire

// File: tb/tb_oled_spi_scheduler.sv
// ---------------------------------------------------------------------------
// tb_oled_spi_scheduler: vector table plus scoreboard bench for oled_spi_scheduler
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_oled_spi_scheduler;
  import oled_spi_scheduler_pkg::*;

  localparam int DW  = 8;
  localparam int GAP = 4;
  localparam int TMO = 40;

  logic          clk = 1'b0;
  logic          rst_i = 1'b1;
  logic          init_req_i = 1'b0, init_dc_i = 1'b0;
  logic [DW-1:0] init_data_i = '0;
  logic          user_req_i = 1'b0, user_dc_i = 1'b0;
  logic [DW-1:0] user_data_i = '0;
  logic          spi_done_i = 1'b0;
  logic          init_ack_o, user_ack_o, spi_start_o, dc_o, busy_o, err_o;
  logic [DW-1:0] spi_data_o;
  logic [1:0]    owner_o;

  always #5 clk = ~clk;

  oled_spi_scheduler #(
    .DATA_WIDTH(DW), .GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk_i(clk), .rst_i(rst_i),
    .init_req_i(init_req_i), .init_dc_i(init_dc_i), .init_data_i(init_data_i), .init_ack_o(init_ack_o),
    .user_req_i(user_req_i), .user_dc_i(user_dc_i), .user_data_i(user_data_i), .user_ack_o(user_ack_o),
    .spi_start_o(spi_start_o), .spi_data_o(spi_data_o), .spi_done_i(spi_done_i),
    .dc_o(dc_o), .owner_o(owner_o), .busy_o(busy_o), .err_o(err_o)
  );

  typedef struct {
    logic          dc;
    logic [DW-1:0] data;
    logic [1:0]    owner;
  } xfer_t;

  typedef struct {
    logic          init_req; logic init_dc; logic [DW-1:0] init_data;
    logic          user_req; logic user_dc; logic [DW-1:0] user_data;
    logic [1:0]    exp_owner; logic exp_dc; logic [DW-1:0] exp_data;
  } vec_t;

  xfer_t init_q[$], user_q[$], exp_q[$];
  int    start_cyc_q[$];
  int    n_vec = 0, n_err = 0, cyc = 0, resp_cnt = 0, done_lat = 5;
  logic  inject_done = 1'b0, own_chk = 1'b0;
  logic [1:0] own_exp = OWNER_NONE;

  function automatic xfer_t mk(input logic dc, input logic [DW-1:0] d, input logic [1:0] o);
    xfer_t x;
    x.dc = dc; x.data = d; x.owner = o;
    return x;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic drive_reqs();
    init_req_i  = (init_q.size() > 0);
    init_dc_i   = (init_q.size() > 0) ? init_q[0].dc   : 1'b0;
    init_data_i = (init_q.size() > 0) ? init_q[0].data : '0;
    user_req_i  = (user_q.size() > 0);
    user_dc_i   = (user_q.size() > 0) ? user_q[0].dc   : 1'b0;
    user_data_i = (user_q.size() > 0) ? user_q[0].data : '0;
  endtask

  // One cycle: sample/check at negedge, then update transmitter and requester models.
  task automatic step();
    xfer_t e;
    @(negedge clk);
    cyc++;
    if (spi_start_o) begin
      start_cyc_q.push_back(cyc);
      if (exp_q.size() == 0) begin
        chk("sb_unexpected_start", 32'(spi_data_o), 32'hFFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        chk("sb_data",  32'(spi_data_o), 32'(e.data));
        chk("sb_dc",    32'(dc_o),       32'(e.dc));
        chk("sb_owner", 32'(owner_o),    32'(e.owner));
        chk("sb_ack",   32'({user_ack_o, init_ack_o}),
            32'({e.owner == OWNER_USER, e.owner == OWNER_INIT}));
      end
    end else if (init_ack_o || user_ack_o) begin
      chk("stray_ack", 32'({user_ack_o, init_ack_o}), 32'd0);
    end
    if (own_chk && busy_o) chk("burst_owner", 32'(owner_o), 32'(own_exp));

    spi_done_i  = inject_done;
    inject_done = 1'b0;
    if (resp_cnt > 0) begin
      resp_cnt--;
      if (resp_cnt == 0) spi_done_i = 1'b1;
    end
    if (spi_start_o && done_lat > 0) resp_cnt = done_lat;

    if (init_ack_o && init_q.size() > 0) void'(init_q.pop_front());
    if (user_ack_o && user_q.size() > 0) void'(user_q.pop_front());
    drive_reqs();
  endtask

  task automatic run_until_idle(input int max_cyc);
    int n = 0;
    do begin
      step();
      n++;
    end while (!(init_q.size() == 0 && user_q.size() == 0 && !busy_o && resp_cnt == 0) && n < max_cyc);
    if (busy_o || init_q.size() != 0 || user_q.size() != 0)
      chk("idle_timeout", 32'(busy_o), 32'd0);
  endtask

  task automatic wait_start(input int max_cyc);
    int n = 0;
    do begin
      step();
      n++;
    end while (!spi_start_o && n < max_cyc);
    if (!spi_start_o) chk("start_timeout", 32'(spi_start_o), 32'd1);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_start"},    32'(spi_start_o), 32'd0);
    chk({tag, "_acks"},     32'({init_ack_o, user_ack_o}), 32'd0);
    chk({tag, "_data"},     32'(spi_data_o), 32'd0);
    chk({tag, "_dc"},       32'(dc_o), 32'd0);
    chk({tag, "_owner"},    32'(owner_o), 32'(OWNER_NONE));
    chk({tag, "_busy"},     32'(busy_o), 32'd0);
    chk({tag, "_err"},      32'(err_o), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[6];
    vec_t v;
    int   s;

    vecs[0] = '{1'b1, 1'b0, 8'hAE, 1'b0, 1'b0, 8'h00, OWNER_INIT, 1'b0, 8'hAE};
    vecs[1] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 8'h5A, OWNER_USER, 1'b1, 8'h5A};
    vecs[2] = '{1'b1, 1'b1, 8'h00, 1'b1, 1'b0, 8'hFF, OWNER_INIT, 1'b1, 8'h00};
    vecs[3] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'hFF, OWNER_USER, 1'b0, 8'hFF};
    vecs[4] = '{1'b1, 1'b1, 8'hFF, 1'b0, 1'b0, 8'h00, OWNER_INIT, 1'b1, 8'hFF};
    vecs[5] = '{1'b1, 1'b0, 8'h72, 1'b1, 1'b1, 8'hA0, OWNER_INIT, 1'b0, 8'h72};

    repeat (2) step();
    chk_reset_outputs("reset");
    rst_i = 1'b0;
    repeat (3) step();

    // Single-byte arbitration vectors; when both request, user follows init.
    for (int i = 0; i < 6; i++) begin
      v = vecs[i];
      if (v.init_req) init_q.push_back(mk(v.init_dc, v.init_data, OWNER_INIT));
      if (v.user_req) user_q.push_back(mk(v.user_dc, v.user_data, OWNER_USER));
      exp_q.push_back(mk(v.exp_dc, v.exp_data, v.exp_owner));
      if (v.init_req && v.user_req) exp_q.push_back(mk(v.user_dc, v.user_data, OWNER_USER));
      drive_reqs();
      run_until_idle(200);
      chk("vec_owner_idle", 32'(owner_o), 32'(OWNER_NONE));
      chk("vec_err",        32'(err_o),   32'd0);
    end

    // Three-byte init burst, done 16 cycles after each start.
    done_lat = 16;
    own_chk  = 1'b1;
    own_exp  = OWNER_INIT;
    start_cyc_q.delete();
    foreach (vecs[0].init_data[b]) begin end
    init_q.push_back(mk(1'b0, 8'hAE, OWNER_INIT));
    init_q.push_back(mk(1'b0, 8'hA0, OWNER_INIT));
    init_q.push_back(mk(1'b0, 8'h72, OWNER_INIT));
    exp_q.push_back(mk(1'b0, 8'hAE, OWNER_INIT));
    exp_q.push_back(mk(1'b0, 8'hA0, OWNER_INIT));
    exp_q.push_back(mk(1'b0, 8'h72, OWNER_INIT));
    drive_reqs();
    run_until_idle(300);
    own_chk = 1'b0;
    chk("burst_starts", 32'(start_cyc_q.size()), 32'd3);
    for (int i = 1; i < start_cyc_q.size(); i++)
      chk("burst_spacing", 32'(start_cyc_q[i] - start_cyc_q[i-1]), 32'(16 + GAP + 1));
    chk("burst_owner_end", 32'(owner_o), 32'(OWNER_NONE));

    // Simultaneous requests: the whole init burst goes before the user byte.
    done_lat = 6;
    init_q.push_back(mk(1'b0, 8'hA1, OWNER_INIT));
    init_q.push_back(mk(1'b0, 8'hA2, OWNER_INIT));
    user_q.push_back(mk(1'b1, 8'h5A, OWNER_USER));
    exp_q.push_back(mk(1'b0, 8'hA1, OWNER_INIT));
    exp_q.push_back(mk(1'b0, 8'hA2, OWNER_INIT));
    exp_q.push_back(mk(1'b1, 8'h5A, OWNER_USER));
    drive_reqs();
    run_until_idle(300);

    // Init rising mid user burst must wait for the burst to finish.
    user_q.push_back(mk(1'b1, 8'h10, OWNER_USER));
    user_q.push_back(mk(1'b1, 8'h11, OWNER_USER));
    user_q.push_back(mk(1'b1, 8'h12, OWNER_USER));
    exp_q.push_back(mk(1'b1, 8'h10, OWNER_USER));
    exp_q.push_back(mk(1'b1, 8'h11, OWNER_USER));
    exp_q.push_back(mk(1'b1, 8'h12, OWNER_USER));
    drive_reqs();
    wait_start(50);
    step();
    init_q.push_back(mk(1'b0, 8'hC0, OWNER_INIT));
    exp_q.push_back(mk(1'b0, 8'hC0, OWNER_INIT));
    drive_reqs();
    run_until_idle(300);

    // Done arriving in the last allowed cycle is accepted without error.
    done_lat = TMO;
    init_q.push_back(mk(1'b0, 8'h21, OWNER_INIT));
    exp_q.push_back(mk(1'b0, 8'h21, OWNER_INIT));
    drive_reqs();
    run_until_idle(300);
    chk("tmo_edge_err", 32'(err_o), 32'd0);

    // No done at all: timeout sets sticky error and returns to idle.
    done_lat = 0;
    init_q.push_back(mk(1'b0, 8'h33, OWNER_INIT));
    exp_q.push_back(mk(1'b0, 8'h33, OWNER_INIT));
    drive_reqs();
    wait_start(50);
    s = cyc;
    while (cyc < s + TMO) step();
    chk("tmo_err_before", 32'(err_o),  32'd0);
    chk("tmo_busy_before", 32'(busy_o), 32'd1);
    step();
    chk("tmo_err_set",   32'(err_o),   32'd1);
    chk("tmo_busy",      32'(busy_o),  32'd0);
    chk("tmo_owner",     32'(owner_o), 32'(OWNER_NONE));
    done_lat = 8;
    user_q.push_back(mk(1'b1, 8'h44, OWNER_USER));
    exp_q.push_back(mk(1'b1, 8'h44, OWNER_USER));
    drive_reqs();
    run_until_idle(200);
    chk("err_sticky", 32'(err_o), 32'd1);

    // Reset during WAIT_DONE, then spurious done pulses after release.
    init_q.push_back(mk(1'b1, 8'h99, OWNER_INIT));
    exp_q.push_back(mk(1'b1, 8'h99, OWNER_INIT));
    drive_reqs();
    wait_start(50);
    repeat (3) step();
    rst_i = 1'b1;
    step();
    chk_reset_outputs("mid_rst");
    step();
    rst_i = 1'b0;
    for (int k = 0; k < 10; k++) begin
      if (k == 4) inject_done = 1'b1;
      step();
      chk_reset_outputs("post_rst");
    end

    // Request held through reset: start no earlier than two cycles after release.
    rst_i = 1'b1;
    step();
    user_q.push_back(mk(1'b1, 8'h5A, OWNER_USER));
    exp_q.push_back(mk(1'b1, 8'h5A, OWNER_USER));
    drive_reqs();
    step();
    rst_i = 1'b0;
    step();
    chk("rel_start_c1", 32'(spi_start_o), 32'd0);
    step();
    chk("rel_start_c2", 32'(spi_start_o), 32'd0);
    step();
    chk("rel_start_c3", 32'(spi_start_o), 32'd1);
    run_until_idle(200);

    chk("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
